// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer slice.
//   XLEN_DEF : default data/address width
//   REG_W    : architectural register index width
//   kind_e   : instruction kind carried by each entry
package rob_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_W    = 5;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_NOP    = 2'd3
  } kind_e;

endpackage

// File: rtl/param_reorder_buffer_if.sv
// Dispatch and store-to-memory handshake bundle of the reorder buffer.
//   disp_*       : instruction allocation (valid/ready, tag = tail index)
//   st_req_valid : head store ready to go to memory, with st_addr/st_data
//   st_ack       : memory accepted the store
// master = instruction front end / memory side, slave = reorder buffer.
interface param_reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned XLEN  = XLEN_DEF
);

  logic             disp_valid;
  logic             disp_ready;
  logic [IDX_W-1:0] disp_tag;
  logic [XLEN-1:0]  disp_pc;
  logic [XLEN-1:0]  disp_pred_pc;
  logic [REG_W-1:0] disp_rd;
  logic [1:0]       disp_kind;

  logic             st_req_valid;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_data;
  logic             st_ack;

  modport master (
    output disp_valid, disp_pc, disp_pred_pc, disp_rd, disp_kind, st_ack,
    input  disp_ready, disp_tag, st_req_valid, st_addr, st_data
  );

  modport slave (
    input  disp_valid, disp_pc, disp_pred_pc, disp_rd, disp_kind, st_ack,
    output disp_ready, disp_tag, st_req_valid, st_addr, st_data
  );

endinterface

// File: rtl/rob_ring_ptr.sv
// Wrap-around ring pointer for the reorder buffer.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   inc      : advance by one, wrapping DEPTH-1 -> 0
//   clr      : return to 0 (takes priority over inc)
//   ptr      : current pointer value
module rob_ring_ptr #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/param_reorder_buffer.sv
// Parametrised in-order-retire reorder buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   rdy             : global enable, low freezes all state
//   bus             : dispatch and store handshakes (slave side)
//   wb_alu_*        : ALU writeback (value, actual next pc)
//   wb_lsu_*        : LSU writeback (store data, store address)
//   q0_*, q1_*      : combinational operand lookup with writeback bypass
//   commit_*        : registered one-cycle register-file retire
//   bp_*            : registered one-cycle branch predictor update
//   flush, flush_pc : registered one-cycle misprediction redirect
//   count           : occupancy
module param_reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  param_reorder_buffer_if.slave bus,
  input  logic                 wb_alu_valid,
  input  logic [IDX_W-1:0]     wb_alu_tag,
  input  logic [XLEN-1:0]      wb_alu_value,
  input  logic [XLEN-1:0]      wb_alu_npc,
  input  logic                 wb_lsu_valid,
  input  logic [IDX_W-1:0]     wb_lsu_tag,
  input  logic [XLEN-1:0]      wb_lsu_value,
  input  logic [XLEN-1:0]      wb_lsu_addr,
  input  logic [IDX_W-1:0]     q0_tag,
  input  logic [IDX_W-1:0]     q1_tag,
  output logic                 q0_ready,
  output logic                 q1_ready,
  output logic [XLEN-1:0]      q0_value,
  output logic [XLEN-1:0]      q1_value,
  output logic                 commit_valid,
  output logic [REG_W-1:0]     commit_rd,
  output logic [XLEN-1:0]      commit_value,
  output logic [IDX_W-1:0]     commit_tag,
  output logic                 bp_valid,
  output logic [XLEN-1:0]      bp_pc,
  output logic                 bp_taken,
  output logic                 flush,
  output logic [XLEN-1:0]      flush_pc,
  output logic [IDX_W:0]       count
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_ready;
  kind_e            ent_kind  [DEPTH];
  logic [REG_W-1:0] ent_rd    [DEPTH];
  logic [XLEN-1:0]  ent_pc    [DEPTH];
  logic [XLEN-1:0]  ent_pred  [DEPTH];
  logic [XLEN-1:0]  ent_value [DEPTH];
  logic [XLEN-1:0]  ent_npc   [DEPTH];
  logic [XLEN-1:0]  ent_addr  [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  kind_e            head_kind;
  logic             full;
  logic             head_ok;
  logic             do_disp;
  logic             do_ret;
  logic             mispredict;
  logic             alu_hit;
  logic             lsu_hit;

  assign full      = (count == (IDX_W+1)'(DEPTH));
  assign head_kind = ent_kind[head];
  assign head_ok   = ent_valid[head] && ent_ready[head];

  assign bus.disp_ready = !full && !flush;
  assign bus.disp_tag   = tail;
  assign do_disp        = rdy && bus.disp_valid && bus.disp_ready;

  // Store outputs are forced to zero when no request is presented so a
  // reset drops them immediately even though entry payloads are not reset.
  assign bus.st_req_valid = head_ok && (head_kind == KIND_STORE) && !flush;
  assign bus.st_addr      = bus.st_req_valid ? ent_addr[head]  : '0;
  assign bus.st_data      = bus.st_req_valid ? ent_value[head] : '0;

  assign do_ret = rdy && head_ok &&
                  ((head_kind != KIND_STORE) || (bus.st_ack && bus.st_req_valid));
  assign mispredict = do_ret && (head_kind == KIND_BRANCH) &&
                      (ent_npc[head] != ent_pred[head]);

  // Writebacks only land on allocated entries; stale tags fall through.
  assign alu_hit = rdy && wb_alu_valid && ent_valid[wb_alu_tag];
  assign lsu_hit = rdy && wb_lsu_valid && ent_valid[wb_lsu_tag];

  rob_ring_ptr #(.DEPTH(DEPTH), .W(IDX_W)) u_head (
    .clk(clk), .rst(rst), .inc(do_ret), .clr(mispredict), .ptr(head)
  );

  rob_ring_ptr #(.DEPTH(DEPTH), .W(IDX_W)) u_tail (
    .clk(clk), .rst(rst), .inc(do_disp), .clr(mispredict), .ptr(tail)
  );

  // Occupancy and entry status. A mispredict discards everything, including
  // an instruction dispatched on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_ready <= '0;
      count     <= '0;
    end else if (mispredict) begin
      ent_valid <= '0;
      ent_ready <= '0;
      count     <= '0;
    end else begin
      if (alu_hit) ent_ready[wb_alu_tag] <= 1'b1;
      if (lsu_hit) ent_ready[wb_lsu_tag] <= 1'b1;
      if (do_disp) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
      end
      if (do_ret) ent_valid[head] <= 1'b0;
      count <= count + (IDX_W+1)'(do_disp) - (IDX_W+1)'(do_ret);
    end
  end

  // Entry payload; meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (do_disp) begin
      ent_kind[tail] <= kind_e'(bus.disp_kind);
      ent_rd[tail]   <= bus.disp_rd;
      ent_pc[tail]   <= bus.disp_pc;
      ent_pred[tail] <= bus.disp_pred_pc;
    end
    if (alu_hit) begin
      ent_value[wb_alu_tag] <= wb_alu_value;
      ent_npc[wb_alu_tag]   <= wb_alu_npc;
    end
    // Placed after the ALU write so the LSU value wins on a shared tag.
    if (lsu_hit) begin
      ent_value[wb_lsu_tag] <= wb_lsu_value;
      ent_addr[wb_lsu_tag]  <= wb_lsu_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      bp_valid     <= 1'b0;
      bp_pc        <= '0;
      bp_taken     <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      bp_valid     <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= do_ret && ((head_kind == KIND_REG) ||
                                 ((head_kind == KIND_BRANCH) && (ent_rd[head] != '0)));
      bp_valid     <= do_ret && (head_kind == KIND_BRANCH);
      flush        <= mispredict;
      if (do_ret) begin
        commit_rd    <= ent_rd[head];
        commit_value <= ent_value[head];
        commit_tag   <= head;
        bp_pc        <= ent_pc[head];
        bp_taken     <= (ent_npc[head] != ent_pc[head] + XLEN'(4));
      end
      if (mispredict) flush_pc <= ent_npc[head];
    end
  end

  // Returns {ready, value}; a same-cycle writeback to the tag bypasses.
  function automatic logic [XLEN:0] lookup(input logic [IDX_W-1:0] t);
    logic [XLEN:0] r;
    r = (ent_valid[t] && ent_ready[t]) ? {1'b1, ent_value[t]} : '0;
    if (alu_hit && (wb_alu_tag == t)) r = {1'b1, wb_alu_value};
    if (lsu_hit && (wb_lsu_tag == t)) r = {1'b1, wb_lsu_value};
    return r;
  endfunction

  assign {q0_ready, q0_value} = lookup(q0_tag);
  assign {q1_ready, q1_value} = lookup(q1_tag);

endmodule

// File: tb/tb_param_reorder_buffer.sv
module tb_param_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst4, rst16, rdy;
  logic        disp_valid, st_ack;
  logic [31:0] disp_pc, disp_pred_pc;
  logic [4:0]  disp_rd;
  logic [1:0]  disp_kind;
  logic        wb_alu_valid, wb_lsu_valid;
  logic [3:0]  wb_alu_tag, wb_lsu_tag, q0_tag, q1_tag;
  logic [31:0] wb_alu_value, wb_alu_npc, wb_lsu_value, wb_lsu_addr;

  logic a_q0_ready, a_q1_ready, a_commit_valid, a_bp_valid, a_bp_taken, a_flush;
  logic [31:0] a_q0_value, a_q1_value, a_commit_value, a_bp_pc, a_flush_pc;
  logic [4:0] a_commit_rd;
  logic [1:0] a_commit_tag;
  logic [2:0] a_count;

  logic b_q0_ready, b_q1_ready, b_commit_valid, b_bp_valid, b_bp_taken, b_flush;
  logic [31:0] b_q0_value, b_q1_value, b_commit_value, b_bp_pc, b_flush_pc;
  logic [4:0] b_commit_rd;
  logic [3:0] b_commit_tag;
  logic [4:0] b_count;

  int checks = 0;
  int errors = 0;

  param_reorder_buffer_if #(.IDX_W(2), .XLEN(32)) if4 ();
  param_reorder_buffer_if #(.IDX_W(4), .XLEN(32)) if16 ();

  assign if4.disp_valid   = disp_valid;
  assign if4.disp_pc      = disp_pc;
  assign if4.disp_pred_pc = disp_pred_pc;
  assign if4.disp_rd      = disp_rd;
  assign if4.disp_kind    = disp_kind;
  assign if4.st_ack       = st_ack;
  assign if16.disp_valid   = disp_valid;
  assign if16.disp_pc      = disp_pc;
  assign if16.disp_pred_pc = disp_pred_pc;
  assign if16.disp_rd      = disp_rd;
  assign if16.disp_kind    = disp_kind;
  assign if16.st_ack       = st_ack;

  param_reorder_buffer #(.DEPTH(4), .IDX_W(2), .XLEN(32)) dut4 (
    .clk(clk), .rst(rst4), .rdy(rdy), .bus(if4),
    .wb_alu_valid(wb_alu_valid), .wb_alu_tag(wb_alu_tag[1:0]),
    .wb_alu_value(wb_alu_value), .wb_alu_npc(wb_alu_npc),
    .wb_lsu_valid(wb_lsu_valid), .wb_lsu_tag(wb_lsu_tag[1:0]),
    .wb_lsu_value(wb_lsu_value), .wb_lsu_addr(wb_lsu_addr),
    .q0_tag(q0_tag[1:0]), .q1_tag(q1_tag[1:0]),
    .q0_ready(a_q0_ready), .q1_ready(a_q1_ready),
    .q0_value(a_q0_value), .q1_value(a_q1_value),
    .commit_valid(a_commit_valid), .commit_rd(a_commit_rd),
    .commit_value(a_commit_value), .commit_tag(a_commit_tag),
    .bp_valid(a_bp_valid), .bp_pc(a_bp_pc), .bp_taken(a_bp_taken),
    .flush(a_flush), .flush_pc(a_flush_pc), .count(a_count)
  );

  param_reorder_buffer #(.DEPTH(16), .IDX_W(4), .XLEN(32)) dut16 (
    .clk(clk), .rst(rst16), .rdy(rdy), .bus(if16),
    .wb_alu_valid(wb_alu_valid), .wb_alu_tag(wb_alu_tag),
    .wb_alu_value(wb_alu_value), .wb_alu_npc(wb_alu_npc),
    .wb_lsu_valid(wb_lsu_valid), .wb_lsu_tag(wb_lsu_tag),
    .wb_lsu_value(wb_lsu_value), .wb_lsu_addr(wb_lsu_addr),
    .q0_tag(q0_tag), .q1_tag(q1_tag),
    .q0_ready(b_q0_ready), .q1_ready(b_q1_ready),
    .q0_value(b_q0_value), .q1_value(b_q1_value),
    .commit_valid(b_commit_valid), .commit_rd(b_commit_rd),
    .commit_value(b_commit_value), .commit_tag(b_commit_tag),
    .bp_valid(b_bp_valid), .bp_pc(b_bp_pc), .bp_taken(b_bp_taken),
    .flush(b_flush), .flush_pc(b_flush_pc), .count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dispatch one instruction into the DEPTH=4 buffer, checking the tag it gets.
  task automatic disp_a(input logic [1:0] kind, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] pred,
                        input logic [1:0] exp_tag);
    disp_valid = 1'b1; disp_kind = kind; disp_rd = rd;
    disp_pc = pc; disp_pred_pc = pred;
    #1;
    chk("disp_tag", 64'(if4.disp_tag), 64'(exp_tag));
    tick();
    disp_valid = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; rst16 = 1'b1; rdy = 1'b1;
    disp_valid = 1'b0; st_ack = 1'b0; disp_pc = '0; disp_pred_pc = '0;
    disp_rd = '0; disp_kind = '0;
    wb_alu_valid = 1'b0; wb_lsu_valid = 1'b0; wb_alu_tag = '0; wb_lsu_tag = '0;
    wb_alu_value = '0; wb_alu_npc = '0; wb_lsu_value = '0; wb_lsu_addr = '0;
    q0_tag = '0; q1_tag = '0;
    #2;
    chk("rst_count", 64'(a_count), 0);
    chk("rst_commit_valid", 64'(a_commit_valid), 0);
    chk("rst_flush", 64'(a_flush), 0);
    chk("rst_st_req", 64'(if4.st_req_valid), 0);
    chk("rst_disp_ready", 64'(if4.disp_ready), 1);
    tick(); tick();
    rst4 = 1'b0;

    // Fill DEPTH=4 with REG entries
    for (int i = 0; i < 4; i++)
      disp_a(KIND_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 2'(i));
    chk("full_count", 64'(a_count), 4);
    chk("full_disp_ready", 64'(if4.disp_ready), 0);

    // Writeback tag 0 with a pending dispatch held while full
    disp_valid = 1'b1; disp_kind = KIND_REG; disp_rd = 5'd9;
    disp_pc = 32'h2000; disp_pred_pc = 32'h2004;
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd0; wb_alu_value = 32'h11; wb_alu_npc = 32'h1004;
    q0_tag = 4'd0; q1_tag = 4'd1;
    #1;
    chk("bypass_q0_ready", 64'(a_q0_ready), 1);
    chk("bypass_q0_value", 64'(a_q0_value), 64'h11);
    chk("q1_not_ready", 64'(a_q1_ready), 0);
    tick();
    wb_alu_valid = 1'b0;
    chk("no_commit_yet", 64'(a_commit_valid), 0);
    chk("full_blocks_disp", 64'(a_count), 4);
    chk("stored_q0_value", 64'(a_q0_value), 64'h11);
    tick();
    chk("c0_valid", 64'(a_commit_valid), 1);
    chk("c0_rd", 64'(a_commit_rd), 1);
    chk("c0_value", 64'(a_commit_value), 64'h11);
    chk("c0_tag", 64'(a_commit_tag), 0);
    chk("c0_count_full_retire", 64'(a_count), 3);
    chk("refill_tag", 64'(if4.disp_tag), 0);
    tick();
    disp_valid = 1'b0;
    chk("c0_pulse", 64'(a_commit_valid), 0);
    chk("refill_count", 64'(a_count), 4);

    // Out-of-order completion 3,2,1; tag 3 also sees an LSU/ALU collision
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd3; wb_alu_value = 32'h99;
    wb_lsu_valid = 1'b1; wb_lsu_tag = 4'd3; wb_lsu_value = 32'h33;
    tick();
    wb_lsu_valid = 1'b0;
    chk("ooo_wait3", 64'(a_commit_valid), 0);
    wb_alu_tag = 4'd2; wb_alu_value = 32'h22;
    tick();
    chk("ooo_wait2", 64'(a_commit_valid), 0);
    wb_alu_tag = 4'd1; wb_alu_value = 32'h21;
    tick();
    wb_alu_valid = 1'b0;
    chk("ooo_wait1", 64'(a_commit_valid), 0);
    tick();
    chk("ooo_c1_tag", 64'(a_commit_tag), 1);
    chk("ooo_c1_value", 64'(a_commit_value), 64'h21);
    tick();
    chk("ooo_c2_tag", 64'(a_commit_tag), 2);
    chk("ooo_c2_valid", 64'(a_commit_valid), 1);
    chk("ooo_c2_value", 64'(a_commit_value), 64'h22);
    tick();
    chk("ooo_c3_tag", 64'(a_commit_tag), 3);
    chk("ooo_c3_lsu_wins", 64'(a_commit_value), 64'h33);
    chk("ooo_c3_rd", 64'(a_commit_rd), 4);
    chk("ooo_count", 64'(a_count), 1);
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd0; wb_alu_value = 32'h90;
    tick();
    wb_alu_valid = 1'b0;
    tick();
    chk("c9_rd", 64'(a_commit_rd), 9);
    chk("c9_value", 64'(a_commit_value), 64'h90);
    chk("empty_count", 64'(a_count), 0);

    // Stale writeback to a freed tag must not bypass
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd0; wb_alu_value = 32'h77; q0_tag = 4'd0;
    #1;
    chk("stale_bypass", 64'(a_q0_ready), 0);
    tick();
    wb_alu_valid = 1'b0;
    chk("stale_ready", 64'(a_q0_ready), 0);

    // Mispredicted branch at head with three younger entries
    disp_a(KIND_BRANCH, 5'd5, 32'h100, 32'h104, 2'd1);
    disp_a(KIND_REG, 5'd6, 32'h104, 32'h108, 2'd2);
    disp_a(KIND_REG, 5'd7, 32'h108, 32'h10c, 2'd3);
    disp_a(KIND_REG, 5'd8, 32'h10c, 32'h110, 2'd0);
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd1; wb_alu_value = 32'h104; wb_alu_npc = 32'h200;
    tick();
    wb_alu_valid = 1'b0;
    tick();
    chk("mp_flush", 64'(a_flush), 1);
    chk("mp_flush_pc", 64'(a_flush_pc), 64'h200);
    chk("mp_bp_valid", 64'(a_bp_valid), 1);
    chk("mp_bp_taken", 64'(a_bp_taken), 1);
    chk("mp_bp_pc", 64'(a_bp_pc), 64'h100);
    chk("mp_commit_valid", 64'(a_commit_valid), 1);
    chk("mp_commit_rd", 64'(a_commit_rd), 5);
    chk("mp_count", 64'(a_count), 0);
    chk("mp_disp_ready", 64'(if4.disp_ready), 0);
    tick();
    chk("mp_flush_pulse", 64'(a_flush), 0);
    chk("mp_after_ready", 64'(if4.disp_ready), 1);
    chk("mp_after_tag", 64'(if4.disp_tag), 0);

    // Correctly predicted fall-through branch with rd=0, frozen one cycle
    disp_a(KIND_BRANCH, 5'd0, 32'h300, 32'h304, 2'd0);
    wb_alu_valid = 1'b1; wb_alu_tag = 4'd0; wb_alu_value = 32'h0; wb_alu_npc = 32'h304;
    tick();
    wb_alu_valid = 1'b0;
    rdy = 1'b0;
    tick();
    chk("frz_bp_valid", 64'(a_bp_valid), 0);
    chk("frz_count", 64'(a_count), 1);
    rdy = 1'b1;
    tick();
    chk("br_bp_valid", 64'(a_bp_valid), 1);
    chk("br_bp_taken", 64'(a_bp_taken), 0);
    chk("br_flush", 64'(a_flush), 0);
    chk("br_rd0_no_commit", 64'(a_commit_valid), 0);
    chk("br_count", 64'(a_count), 0);

    // Store held at head until acknowledged
    disp_a(KIND_STORE, 5'd0, 32'h400, 32'h404, 2'd1);
    wb_lsu_valid = 1'b1; wb_lsu_tag = 4'd1; wb_lsu_value = 32'hdead; wb_lsu_addr = 32'h80;
    tick();
    wb_lsu_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_req_valid", 64'(if4.st_req_valid), 1);
      chk("st_addr", 64'(if4.st_addr), 64'h80);
      chk("st_data", 64'(if4.st_data), 64'hdead);
      tick();
      chk("st_no_retire", 64'(a_count), 1);
    end
    rdy = 1'b0; st_ack = 1'b1;
    tick();
    chk("st_ack_frozen", 64'(a_count), 1);
    rdy = 1'b1;
    tick();
    st_ack = 1'b0;
    chk("st_retired", 64'(a_count), 0);
    chk("st_req_clear", 64'(if4.st_req_valid), 0);
    chk("st_no_commit", 64'(a_commit_valid), 0);

    // Reset with three entries and a pending store at head (tag 2)
    disp_a(KIND_STORE, 5'd0, 32'h500, 32'h504, 2'd2);
    disp_a(KIND_REG, 5'd10, 32'h504, 32'h508, 2'd3);
    disp_a(KIND_REG, 5'd11, 32'h508, 32'h50c, 2'd0);
    wb_lsu_valid = 1'b1; wb_lsu_tag = 4'd2; wb_lsu_value = 32'h55; wb_lsu_addr = 32'h44;
    tick();
    wb_lsu_valid = 1'b0;
    chk("pre_rst_st_req", 64'(if4.st_req_valid), 1);
    chk("pre_rst_count", 64'(a_count), 3);
    #2 rst4 = 1'b1;
    #1;
    chk("arst_st_req", 64'(if4.st_req_valid), 0);
    chk("arst_st_addr", 64'(if4.st_addr), 0);
    chk("arst_count", 64'(a_count), 0);
    chk("arst_flush_pc", 64'(a_flush_pc), 0);
    chk("arst_commit_value", 64'(a_commit_value), 0);
    chk("arst_bp_valid", 64'(a_bp_valid), 0);
    tick();
    rst4 = 1'b0;
    #1;
    chk("post_rst_count", 64'(a_count), 0);
    chk("post_rst_ready", 64'(if4.disp_ready), 1);
    chk("post_rst_tag", 64'(if4.disp_tag), 0);

    // DEPTH=16: 20 overlapped dispatch/retire pairs, tags wrap 15 -> 0
    rst4 = 1'b1;
    rst16 = 1'b0;
    tick();
    for (int k = 0; k < 22; k++) begin
      disp_valid   = (k < 20);
      disp_kind    = KIND_REG;
      disp_rd      = 5'((k % 31) + 1);
      disp_pc      = 32'h2000 + 32'(4 * k);
      disp_pred_pc = 32'h2004 + 32'(4 * k);
      wb_alu_valid = (k >= 1) && (k <= 20);
      wb_alu_tag   = (k >= 1) ? 4'((k - 1) % 16) : 4'd0;
      wb_alu_value = 32'h1000 + 32'(k) - 32'd1;
      wb_alu_npc   = 32'h0;
      #1;
      if (k < 20) chk("wrap_disp_tag", 64'(if16.disp_tag), 64'(k % 16));
      tick();
      if (k >= 2) begin
        chk("wrap_commit_valid", 64'(b_commit_valid), 1);
        chk("wrap_commit_tag", 64'(b_commit_tag), 64'((k - 2) % 16));
        chk("wrap_commit_value", 64'(b_commit_value), 64'(32'h1000 + 32'(k - 2)));
        chk("wrap_commit_rd", 64'(b_commit_rd), 64'(((k - 2) % 31) + 1));
      end
      chk("wrap_count", 64'(b_count),
          (k == 0) ? 64'd1 : (k < 20) ? 64'd2 : (k == 20) ? 64'd1 : 64'd0);
    end
    disp_valid = 1'b0;
    wb_alu_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_reorder_buffer.md
PARAM_REORDER_BUFFER -- requirements
Module: param_reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, 4..64.
REQ-002 Parameter IDX_W, default log2(DEPTH): tag width.
REQ-003 Parameter XLEN, default 32: width of data and addresses.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rdy  in  1  global enable; low = freeze.
REQ-007 disp_valid in 1 / disp_ready out 1 / disp_tag out IDX_W  dispatch handshake; disp_tag = tail index.
REQ-008 disp_pc, disp_pred_pc  in  XLEN  instruction pc and predicted next pc.
REQ-009 disp_rd in 5 / disp_kind in 2  destination register; kind encoding 0=REG, 1=BRANCH (may write rd), 2=STORE, 3=NOP.
REQ-010 wb_alu_valid in 1 / wb_alu_tag in IDX_W / wb_alu_value in XLEN / wb_alu_npc in XLEN  ALU writeback; npc = actual next pc.
REQ-011 wb_lsu_valid in 1 / wb_lsu_tag in IDX_W / wb_lsu_value in XLEN / wb_lsu_addr in XLEN  LSU writeback; store data and address.
REQ-012 q0_tag, q1_tag in IDX_W / q0_ready, q1_ready out 1 / q0_value, q1_value out XLEN  operand lookup ports.
REQ-013 commit_valid out 1 / commit_rd out 5 / commit_value out XLEN / commit_tag out IDX_W  register-file retire.
REQ-014 st_req_valid out 1 / st_addr, st_data out XLEN / st_ack in 1  store-to-memory handshake.
REQ-015 bp_valid out 1 / bp_pc out XLEN / bp_taken out 1  predictor update.
REQ-016 flush out 1 / flush_pc out XLEN  misprediction redirect.
REQ-017 count out IDX_W+1  occupancy.

Function
REQ-018 Circular buffer: head, tail, count; pointers wrap DEPTH-1 -> 0; full = count==DEPTH, empty = count==0.
REQ-019 disp_ready = !full && !flush. Dispatch occurs on an edge with disp_valid && disp_ready && rdy: allocate entry at tail, ready=0, tail+1.
REQ-020 Writebacks set ready and store value/npc/addr only if the addressed entry is allocated; stale tags are ignored. Same tag on both ports in one cycle: LSU wins.
REQ-021 Lookup is combinational; a writeback to the queried tag in the same cycle bypasses (ready=1, value = writeback value).
REQ-022 Retire at most one entry per edge, only when head is allocated and ready. A STORE retires only on an edge with st_ack=1.
REQ-023 st_req_valid = head allocated && ready && kind==STORE && !flush; st_addr/st_data are stable until st_ack.
REQ-024 On retire, commit_valid, commit_rd, commit_value and commit_tag are registered and pulse exactly one cycle. commit_valid asserts only for REG, or for BRANCH with rd!=0.
REQ-025 On retire of a BRANCH: bp_valid pulses one cycle; bp_taken = (npc != pc+4).
REQ-026 Mispredict = a retiring BRANCH with npc != pred_pc. On that same edge the branch commits normally and all entries are invalidated (head=tail=0, count=0). flush pulses one cycle with flush_pc = npc.
REQ-027 Simultaneous dispatch and retire: count unchanged, both pointers advance. Full with a retire in the same cycle still blocks dispatch.
REQ-028 rdy=0: state is held, and commit_valid, bp_valid and flush are 0 from the next edge. st_ack is ignored while rdy=0.
REQ-029 No arithmetic overflow: count saturates by construction. pc+4 is computed modulo 2^XLEN.

Reset
REQ-030 rst high clears head, tail, count and all entry valid and ready bits immediately. It also clears commit_valid, bp_valid, flush, st_req_valid, flush_pc and commit_* to 0.
REQ-031 Reset mid-operation discards all entries, including an unacknowledged store. After release, disp_ready=1 and disp_tag=0.

Structure
REQ-032 Shared package rob_pkg SHALL hold the kind encoding, the XLEN default, and the reg-index width.
REQ-033 One sub-module, rob_ring_ptr (parametrised wrap-around pointer with increment and clear), SHALL be instantiated for head and tail.

Verification
REQ-034 DEPTH=4: dispatch 4 REG entries -> disp_ready=0, count=4. Writeback tag 0 value 0x11 -> commit_valid next cycle with rd and value 0x11, count=3.
REQ-035 Out-of-order writeback: tags 2, 1, 0 complete -> commits occur in order 0, 1, 2 on consecutive cycles.
REQ-036 BRANCH pc=0x100, pred_pc=0x104, npc=0x200 at head with 3 younger entries -> flush=1, flush_pc=0x200, bp_taken=1, count=0 the next cycle.
REQ-037 STORE at head, st_ack held low 5 cycles -> st_req_valid held with addr and data stable, no retire. st_ack=1 -> retire, head+1.
REQ-038 Wrap-around: 20 dispatch/retire pairs at DEPTH=16 -> tags wrap 15 -> 0 and ordering is preserved.
REQ-039 rst asserted while count=3 and a store is pending -> all outputs 0 asynchronously, then count=0 after release.
